lock_sequencer: RTL
===================

# lock_sequencer

Sequencing controller for the keypad password lock. Consumes decoded key events from the keypad encoder. Runs digit entry, password comparison, try counting and lockout. Arbitrates the single buzzer between key-click and alarm requests, and drives the 3-digit BCD display bus.

## Interface
Parameters:
- DIGITS, 3: password length in BCD digits; display/compare width is 4*DIGITS.
- MAX_TRIES, 6: failed attempts that force LOCKED.
- CLICK_CYCLES, 10_000_000: key-click duration in clk cycles.
- ALARM_CYCLES, 50_000_000: fail-alarm duration in clk cycles.
- TONE_DIV, 50_000: buzzer half-period in clk cycles.
- LOCK_CYCLES, 500_000_000: lockout duration; used only with LOCKOUT_TIMER_EN.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle pulse per key press.
- key_code  in  4  key code:
  - 0–9: digit.
  - 4'hA: ENTER.
  - 4'hB: CLEAR.
  - 4'hC: ADMIN.
  - Other codes are ignored.
- pass_code  in  4*DIGITS  expected password in BCD, MS digit in the top nibble; sampled at CHECK.
- disp  out  4*DIGITS  display digits; nibble 4'hF = blank digit.
- unlocked  out  1  high in PASS.
- locked  out  1  high in LOCKED.
- tries  out  3  failed-attempt count since last clear.
- buzzer  out  1  square-wave buzzer drive.

## Operation
States: ENTRY, CHECK, PASS, FAIL, LOCKED.

ENTRY:
- A digit key with count < DIGITS shifts into disp: disp <= {disp[4*DIGITS-5:0], code}, and count increments.
- A digit key with count == DIGITS is ignored (no shift, no click).
- CLEAR: disp <= all 4'hF, count <= 0; tries unchanged.
- ENTER with count == DIGITS -> CHECK.
- ENTER with count < DIGITS is ignored.

CHECK:
- Lasts exactly one cycle.
- disp == pass_code -> PASS, and tries <= 0.
- Otherwise -> FAIL, and tries <= tries + 1, saturating at 7.

FAIL:
- Entry actions: alarm request, disp blanked, count <= 0.
- Go to LOCKED if the new tries value >= MAX_TRIES, else go to ENTRY.
- FAIL lasts one cycle.

PASS:
- unlocked = 1.
- disp shows the fixed pattern {4'hA, 4'hB, 4'hC} (the "ASS" glyph codes).
- CLEAR returns to ENTRY with display blanked; all other keys are ignored.

LOCKED:
- locked = 1; disp = all 4'h0.
- Only ADMIN is honoured.
- ADMIN -> ENTRY, tries <= 0, disp blanked.

ADMIN in any state:
- Same effect as in LOCKED.

Buzzer arbitration:
- Click: any accepted key (one that causes a state or display change) requests a click of CLICK_CYCLES.
- Alarm: entering FAIL requests an alarm of ALARM_CYCLES.
- Alarm has priority and pre-empts an active click.
- A click request during an alarm is dropped.
- A new request of equal priority restarts its own timer.
- While a tone is active, buzzer toggles every TONE_DIV cycles, starting at 1 on the request cycle.
- While idle, buzzer = 0.

## Timing
Reset values:
- State = ENTRY, count = 0.
- disp = all 4'hF.
- tries = 0, unlocked = 0, locked = 0, buzzer = 0.
- Tone timers and the divider are cleared.

Latencies:
- key_valid at cycle N -> disp/state update visible at N+1.
- ENTER at N -> CHECK at N+1 -> PASS/FAIL at N+2 -> ENTRY/LOCKED at N+3.
- Buzzer goes high at N+1 for a click; for a fail, at the cycle FAIL is entered.

Ordering and boundaries:
- key_valid is ignored during CHECK and FAIL; no queueing.
- Simultaneous rst and key_valid: rst wins.
- rst mid-tone silences the buzzer the next cycle.
- tries saturates at 7 and never wraps.
- A tone timer expiring on the same cycle as a new request: the request wins and the timer reloads.

## Configuration
LOCKOUT_TIMER_EN:
- Defined: LOCKED also counts LOCK_CYCLES from entry and then returns to ENTRY with tries <= 0. ADMIN still exits immediately.
- Undefined: LOCKED exits only on ADMIN; the lockout counter is not instantiated.

## Structure
Shared package lock_pkg holds:
- Key code constants: KEY_ENTER, KEY_CLEAR, KEY_ADMIN.
- BLANK_NIBBLE.
- The state enum lock_state_t.
- The PASS glyph constant.

Sub-module buzzer_tone:
- Contains the priority request latch, duration counter and TONE_DIV divider.
- Inputs: click_req, alarm_req.
- Output: buzzer.
- Used as the single instance inside lock_sequencer.

## Test plan
For simulation, use small parameter values: CLICK_CYCLES=20, ALARM_CYCLES=50, TONE_DIV=4, LOCK_CYCLES=100.

- pass_code=12'h246; keys 2,4,6,ENTER -> disp 12'hFF2, 12'hF24, 12'h246; unlocked=1 at ENTER+2; disp=12'hABC; tries=0.
- Keys 1,2,3,ENTER -> FAIL at ENTER+2; disp=12'hFFF, tries=1, alarm active; a key during the alarm produces no click.
- Six wrong entries -> locked=1, disp=12'h000, tries=6. Digits are ignored. ADMIN -> ENTRY, tries=0.
  - With LOCKOUT_TIMER_EN: no ADMIN -> auto-exit after 100 cycles.
- Keys 1,2,3,4 -> 4th digit ignored, disp=12'h123. ENTER after 2 digits is ignored. CLEAR -> disp=12'hFFF.
- Click in progress, then a wrong ENTER -> alarm pre-empts and runs the full 50 cycles, buzzer toggling every 4 cycles.
- rst asserted mid-alarm together with key_valid -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared constants and state types for the keypad lock sequencer.
// Holds key codes, the blank/PASS display patterns and the FSM/tone enums.
package lock_pkg;

    localparam logic [3:0] KEY_ENTER    = 4'hA;
    localparam logic [3:0] KEY_CLEAR    = 4'hB;
    localparam logic [3:0] KEY_ADMIN    = 4'hC;
    localparam logic [3:0] BLANK_NIBBLE = 4'hF;

    // "ASS" glyph codes shown while unlocked
    localparam logic [11:0] PASS_GLYPH = {4'hA, 4'hB, 4'hC};

    typedef enum logic [2:0] {
        ST_ENTRY,
        ST_CHECK,
        ST_PASS,
        ST_FAIL,
        ST_LOCKED
    } lock_state_t;

    typedef enum logic [1:0] {
        TONE_IDLE,
        TONE_CLICK,
        TONE_ALARM
    } tone_mode_t;

endpackage

// File: rtl/lock_sequencer_buzzer_tone.sv
// Buzzer arbiter: latches the highest-priority tone request, times its duration
// and divides clk down to a square wave. Alarm pre-empts click; clicks during an alarm are dropped.
module buzzer_tone
    import lock_pkg::*;
#(
    parameter int unsigned CLICK_CYCLES = 10_000_000,
    parameter int unsigned ALARM_CYCLES = 50_000_000,
    parameter int unsigned TONE_DIV     = 50_000
) (
    input  logic clk,
    input  logic rst,
    input  logic click_req,
    input  logic alarm_req,
    output logic buzzer
);

    localparam int unsigned MAX_DUR = (ALARM_CYCLES > CLICK_CYCLES) ? ALARM_CYCLES : CLICK_CYCLES;
    localparam int unsigned DUR_W   = $clog2(MAX_DUR + 1);
    localparam int unsigned DIV_W   = $clog2(TONE_DIV + 1);

    localparam logic [DUR_W-1:0] CLICK_LOAD = DUR_W'(CLICK_CYCLES - 1);
    localparam logic [DUR_W-1:0] ALARM_LOAD = DUR_W'(ALARM_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TONE_DIV - 1);

    tone_mode_t       mode_q, mode_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             buzz_q, buzz_d;

    always_comb begin
        mode_d = mode_q;
        dur_d  = dur_q;
        div_d  = div_q;
        buzz_d = buzz_q;
        // A fresh request wins over a timer expiring in the same cycle
        if (alarm_req) begin
            mode_d = TONE_ALARM;
            dur_d  = ALARM_LOAD;
            div_d  = '0;
            buzz_d = 1'b1;
        end else if (click_req && (mode_q != TONE_ALARM)) begin
            mode_d = TONE_CLICK;
            dur_d  = CLICK_LOAD;
            div_d  = '0;
            buzz_d = 1'b1;
        end else if (mode_q != TONE_IDLE) begin
            if (dur_q == '0) begin
                mode_d = TONE_IDLE;
                div_d  = '0;
                buzz_d = 1'b0;
            end else begin
                dur_d = dur_q - DUR_W'(1);
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    buzz_d = ~buzz_q;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= TONE_IDLE;
            dur_q  <= '0;
            div_q  <= '0;
            buzz_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            dur_q  <= dur_d;
            div_q  <= div_d;
            buzz_q <= buzz_d;
        end
    end

    assign buzzer = buzz_q;

endmodule

// File: rtl/lock_sequencer.sv
// Keypad lock sequencer: digit entry, password check, try counting, lockout and buzzer requests.
// Optional LOCKOUT_TIMER_EN adds a timed automatic exit from LOCKED.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int unsigned DIGITS       = 3,
    parameter int unsigned MAX_TRIES    = 6,
    parameter int unsigned CLICK_CYCLES = 10_000_000,
    parameter int unsigned ALARM_CYCLES = 50_000_000,
    parameter int unsigned TONE_DIV     = 50_000,
    parameter int unsigned LOCK_CYCLES  = 500_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    input  logic [4*DIGITS-1:0]   pass_code,
    output logic [4*DIGITS-1:0]   disp,
    output logic                  unlocked,
    output logic                  locked,
    output logic [2:0]            tries,
    output logic                  buzzer
);

    localparam int unsigned W     = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(DIGITS + 1);
    localparam logic [W-1:0] DISP_BLANK = {DIGITS{BLANK_NIBBLE}};

    lock_state_t      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [W-1:0]     disp_q, disp_d;
    logic [2:0]       tries_q, tries_d;
    logic             click_req, alarm_req;
    logic             lock_expired;

    logic is_digit, key_clear, key_enter, key_admin, entry_full;

    always_comb begin
        is_digit   = key_valid && (key_code <= 4'd9);
        key_clear  = key_valid && (key_code == KEY_CLEAR);
        key_enter  = key_valid && (key_code == KEY_ENTER);
        key_admin  = key_valid && (key_code == KEY_ADMIN);
        entry_full = (32'(count_q) >= DIGITS);
    end

`ifdef LOCKOUT_TIMER_EN
    localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;

    always_comb begin
        lock_cnt_d   = (state_q == ST_LOCKED) ? lock_cnt_q + LOCK_W'(1) : '0;
        lock_expired = (state_q == ST_LOCKED) && (lock_cnt_q == LOCK_W'(LOCK_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) lock_cnt_q <= '0;
        else     lock_cnt_q <= lock_cnt_d;
    end
`else
    always_comb lock_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        disp_d    = disp_q;
        tries_d   = tries_q;
        click_req = 1'b0;
        alarm_req = 1'b0;
        case (state_q)
            ST_ENTRY: begin
                if (is_digit && !entry_full) begin
                    disp_d    = {disp_q[W-5:0], key_code};
                    count_d   = count_q + CNT_W'(1);
                    click_req = 1'b1;
                end else if (key_clear) begin
                    disp_d    = DISP_BLANK;
                    count_d   = '0;
                    click_req = 1'b1;
                end else if (key_enter && entry_full) begin
                    state_d   = ST_CHECK;
                    click_req = 1'b1;
                end else if (key_admin) begin
                    disp_d    = DISP_BLANK;
                    count_d   = '0;
                    tries_d   = '0;
                    click_req = 1'b1;
                end
            end
            ST_CHECK: begin
                if (disp_q == pass_code) begin
                    state_d = ST_PASS;
                    tries_d = '0;
                end else begin
                    // FAIL entry actions are applied here so they are visible in FAIL itself
                    state_d   = ST_FAIL;
                    tries_d   = (tries_q == 3'd7) ? tries_q : tries_q + 3'd1;
                    disp_d    = DISP_BLANK;
                    count_d   = '0;
                    alarm_req = 1'b1;
                end
            end
            ST_FAIL: begin
                state_d = (32'(tries_q) >= MAX_TRIES) ? ST_LOCKED : ST_ENTRY;
            end
            ST_PASS: begin
                if (key_clear || key_admin) begin
                    state_d   = ST_ENTRY;
                    disp_d    = DISP_BLANK;
                    count_d   = '0;
                    click_req = 1'b1;
                    if (key_admin) tries_d = '0;
                end
            end
            ST_LOCKED: begin
                if (key_admin || lock_expired) begin
                    state_d   = ST_ENTRY;
                    disp_d    = DISP_BLANK;
                    count_d   = '0;
                    tries_d   = '0;
                    click_req = key_admin;
                end
            end
            default: state_d = ST_ENTRY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ENTRY;
            count_q <= '0;
            disp_q  <= DISP_BLANK;
            tries_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            disp_q  <= disp_d;
            tries_q <= tries_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_PASS:   disp = W'(PASS_GLYPH);
            ST_LOCKED: disp = '0;
            default:   disp = disp_q;
        endcase
        unlocked = (state_q == ST_PASS);
        locked   = (state_q == ST_LOCKED);
        tries    = tries_q;
    end

    buzzer_tone #(
        .CLICK_CYCLES (CLICK_CYCLES),
        .ALARM_CYCLES (ALARM_CYCLES),
        .TONE_DIV     (TONE_DIV)
    ) u_buzzer_tone (
        .clk       (clk),
        .rst       (rst),
        .click_req (click_req),
        .alarm_req (alarm_req),
        .buzzer    (buzzer)
    );

endmodule
